eth_gmii_tx_framer: RTL and testbench
=====================================

Name: eth_gmii_tx_framer

Overview:
- Transmit framing stage in the clk250_i domain of the Ethernet controller.
- Consumes the raw frame byte stream drained from the TX packet buffer and produces a byte-wide GMII stream for the RGMII DDR output stage.
- Inserts preamble/SFD, pads short frames, appends the CRC-32 FCS and enforces inter-frame gap.
- Signals underrun as a GMII transmit error.

Parameters:
- min_frame_p, 60: minimum frame length in bytes, excluding FCS, used for padding.
- pad_en_p, 1: 1 = pad short frames with 0x00 up to min_frame_p; 0 = no padding.
- ifg_bytes_p, 12: idle byte times inserted after each frame, minimum 1.

Ports:
- clk250_i  in  1  block clock.
- reset_r_lo  in  1  reset: asynchronous, active-high, in the clk250_i domain.
- en_i  in  1  byte-time strobe (125 MHz rate); all state and outputs advance only on edges where en_i=1.
- s_data_i  in  8  frame byte (destination MAC first).
- s_valid_i  in  1  s_data_i valid.
- s_last_i  in  1  final byte of frame.
- s_ready_o  out  1  byte accepted when s_valid_i & s_ready_o.
- gmii_txd_o  out  8  transmit byte; 0x00 when gmii_tx_en_o=0.
- gmii_tx_en_o  out  1  transmit enable.
- gmii_tx_er_o  out  1  transmit error.
- busy_o  out  1  state != IDLE.
- frame_done_o  out  1  one-clk250 pulse when the last FCS byte is driven.
- underrun_o  out  1  one-clk250 pulse on an aborted frame.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - state = IDLE; all outputs 0, including gmii_tx_en_o and gmii_tx_er_o.
  - Counters and CRC are cleared to their initial values.
  - A frame in flight is dropped silently; no FCS and no tx_er is sent.
- Output timing:
  - All GMII outputs are registered and change only on edges where en_i=1.
  - Between strobes they hold their value.
  - frame_done_o and underrun_o are single clk250_i-cycle pulses, asserted on the enabled edge concerned.
- Handshake:
  - s_ready_o is combinational: (state==DATA) & en_i.
  - The accepted byte appears on gmii_txd_o after the same edge, so data latency is 1 clk250 cycle from the accepting edge.
- States:
  - IDLE: gmii_tx_en_o=0. On an enabled edge with s_valid_i=1, drive 0x55 with tx_en=1, set the preamble count to 1 and go to PREAMBLE. s_valid_i is not consumed here.
  - PREAMBLE: drive 0x55 until 7 bytes have been sent, then 0xD5 (SFD), then go to DATA. Preamble/SFD bytes are excluded from the CRC.
  - DATA: on an enabled edge with s_valid_i=1:
    - Drive s_data_i, update the CRC and increment the 11-bit byte count (saturating at 2047).
    - If s_last_i=1, go to PAD when pad_en_p=1 and count+1 < min_frame_p; otherwise go to FCS.
  - DATA, underrun: on an enabled edge with s_valid_i=0:
    - Drive txd=0x00, tx_en=1, tx_er=1 for that byte time and pulse underrun_o.
    - Go to IFG; no FCS is sent.
  - PAD: drive 0x00 and include it in the CRC until count = min_frame_p, then go to FCS.
  - FCS:
    - Drive the 4 bytes of ~crc, least-significant byte first.
    - frame_done_o pulses on the 4th byte; then go to IFG.
  - IFG:
    - tx_en=0, tx_er=0, txd=0 for ifg_bytes_p enabled cycles, then go to IDLE.
    - s_valid_i held high starts the next preamble on the enabled edge after the last IFG byte time.
- CRC:
  - IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Byte-serial, LSB-first; transmitted value is the complement.
  - Reinitialised on entry to PREAMBLE.
- gmii_tx_er_o is 1 only for the single underrun byte time.
- s_last_i is ignored when not accompanied by an accepted byte.
- No maximum frame length is enforced.

Test Plan:
1. pad_en_p=0, en_i=1, frame ASCII "123456789" (0x31..0x39):
   - gmii_txd_o sequence is 55×7, D5, 31..39, 26 39 F4 CB with tx_en=1 (21 cycles).
   - frame_done_o pulses on CB.
   - Then 12 cycles with tx_en=0.
2. pad_en_p=1, 1-byte frame 0xAB:
   - Output is preamble/SFD, AB, 59×0x00, 4 FCS bytes.
   - 72 tx_en cycles total.
   - FCS equals the reference CRC of AB followed by 59 zero bytes.
3. en_i asserted every other clk250 cycle, same stimulus as test 1:
   - Identical byte sequence.
   - Outputs change only after enabled edges.
   - s_ready_o never high while en_i=0.
4. Underrun, 20-byte frame with s_valid_i dropped after byte 3:
   - Next byte time drives txd=00, tx_en=1, tx_er=1.
   - underrun_o pulses once; no FCS is sent.
   - 12 idle byte times follow, then IDLE.
5. Back-to-back 64-byte frames with s_valid_i held high:
   - The second frame's first 0x55 occurs exactly 13 enabled edges after the last FCS byte (12 idle).
   - No byte is lost or duplicated.
6. Assert reset_r_lo asynchronously mid-DATA:
   - gmii_tx_en_o falls without a clock edge; busy_o=0.
   - After release, a new "123456789" frame reproduces test 1 exactly.

Source files
------------

// File: rtl/eth_gmii_tx_framer.sv
// rtl/eth_gmii_tx_framer.sv - GMII transmit framer: preamble/SFD, padding, CRC-32 FCS, IFG, underrun
module eth_gmii_tx_framer #(
    parameter int min_frame_p = 60,
    parameter int pad_en_p    = 1,
    parameter int ifg_bytes_p = 12
) (
    input  logic       clk250_i,
    input  logic       reset_r_lo,
    input  logic       en_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       gmii_tx_er_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       underrun_o
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_DATA, ST_PAD, ST_FCS, ST_IFG
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [11:0] MIN_LEN  = 12'(min_frame_p);
    localparam logic [15:0] IFG_LAST = 16'(ifg_bytes_p - 1);
    localparam logic        PAD_EN   = (pad_en_p != 0);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [10:0] len_q;
    logic [31:0] crc_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic        done_q;
    logic        underrun_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    logic [7:0]  crc_in;
    logic [31:0] crc_d;
    logic [11:0] len_inc;
    logic [10:0] len_d;

    // Pad bytes feed zeros into the CRC; the length counter saturates at 2047.
    assign crc_in  = (state_q == ST_PAD) ? 8'h00 : s_data_i;
    assign crc_d   = crc_byte(crc_q, crc_in);
    assign len_inc = {1'b0, len_q} + 12'd1;
    assign len_d   = (len_q == 11'h7FF) ? len_q : len_inc[10:0];

    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            crc_q      <= 32'hFFFFFFFF;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (en_i) begin
                case (state_q)
                    ST_IDLE: begin
                        txd_q   <= 8'h00;
                        tx_en_q <= 1'b0;
                        tx_er_q <= 1'b0;
                        if (s_valid_i) begin
                            txd_q   <= 8'h55;
                            tx_en_q <= 1'b1;
                            cnt_q   <= 16'd1;
                            crc_q   <= 32'hFFFFFFFF;
                            len_q   <= '0;
                            state_q <= ST_PREAMBLE;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (cnt_q == 16'd7) begin
                            txd_q   <= 8'hD5;
                            state_q <= ST_DATA;
                        end else begin
                            txd_q <= 8'h55;
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (s_valid_i) begin
                            txd_q <= s_data_i;
                            crc_q <= crc_d;
                            len_q <= len_d;
                            if (s_last_i) begin
                                cnt_q   <= '0;
                                state_q <= (PAD_EN && (len_inc < MIN_LEN)) ? ST_PAD : ST_FCS;
                            end
                        end else begin
                            txd_q      <= 8'h00;
                            tx_er_q    <= 1'b1;
                            underrun_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= ST_IFG;
                        end
                    end
                    ST_PAD: begin
                        txd_q <= 8'h00;
                        crc_q <= crc_d;
                        len_q <= len_d;
                        if (len_inc >= MIN_LEN) begin
                            cnt_q   <= '0;
                            state_q <= ST_FCS;
                        end
                    end
                    ST_FCS: begin
                        // Shift the CRC down so the next FCS byte is always in the low octet.
                        txd_q <= ~crc_q[7:0];
                        crc_q <= {8'h00, crc_q[31:8]};
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == 16'd3) begin
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_IFG;
                        end
                    end
                    ST_IFG: begin
                        txd_q   <= 8'h00;
                        tx_en_q <= 1'b0;
                        tx_er_q <= 1'b0;
                        if (cnt_q == IFG_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_ready_o    = (state_q == ST_DATA) & en_i;
    assign gmii_txd_o   = txd_q;
    assign gmii_tx_en_o = tx_en_q;
    assign gmii_tx_er_o = tx_er_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = done_q;
    assign underrun_o   = underrun_q;
endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// tb/tb_eth_gmii_tx_framer.sv - self-checking bench for eth_gmii_tx_framer
`timescale 1ns/1ps
module tb_eth_gmii_tx_framer;
    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic       reset_r_lo, en_i, s_valid_i, s_last_i;
    logic [7:0] s_data_i;

    logic       n_ready, n_en, n_er, n_busy, n_done, n_und;
    logic [7:0] n_txd;
    logic       p_ready, p_en, p_er, p_busy, p_done, p_und;
    logic [7:0] p_txd;

    eth_gmii_tx_framer #(.min_frame_p(60), .pad_en_p(0), .ifg_bytes_p(12)) u_nopad (
        .clk250_i(clk), .reset_r_lo(reset_r_lo), .en_i(en_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(n_ready),
        .gmii_txd_o(n_txd), .gmii_tx_en_o(n_en), .gmii_tx_er_o(n_er),
        .busy_o(n_busy), .frame_done_o(n_done), .underrun_o(n_und));

    eth_gmii_tx_framer #(.min_frame_p(60), .pad_en_p(1), .ifg_bytes_p(12)) u_pad (
        .clk250_i(clk), .reset_r_lo(reset_r_lo), .en_i(en_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(p_ready),
        .gmii_txd_o(p_txd), .gmii_tx_en_o(p_en), .gmii_tx_er_o(p_er),
        .busy_o(p_busy), .frame_done_o(p_done), .underrun_o(p_und));

    logic       sel;
    logic       o_ready, o_en, o_er, o_busy, o_done, o_und;
    logic [7:0] o_txd;
    assign o_ready = sel ? p_ready : n_ready;
    assign o_en    = sel ? p_en    : n_en;
    assign o_er    = sel ? p_er    : n_er;
    assign o_busy  = sel ? p_busy  : n_busy;
    assign o_done  = sel ? p_done  : n_done;
    assign o_und   = sel ? p_und   : n_und;
    assign o_txd   = sel ? p_txd   : n_txd;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
        logic       done;
        logic       und;
    } beat_t;

    typedef struct {
        bit          pad;
        int          en_mode;
        int          nfr;
        int          len;
        int          kind;
        bit          abort;
        int          exp_txen;
        logic [31:0] exp_fcs;
    } vec_t;

    beat_t       cap[$];
    beat_t       exp_q[$];
    logic [7:0]  byte_q[$];
    bit          last_q[$];
    int          flen_q[$];
    bit          fab_q[$];
    logic [31:0] crc_tbl[256];
    int          ptr, cyc, en_mode;
    int          hold_err, ready_err, pulse_err;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic init_tbl();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[i] = c;
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
        return crc_tbl[crc[7:0] ^ b] ^ (crc >> 8);
    endfunction

    function automatic beat_t mk(input logic en, input logic er, input logic [7:0] d,
                                 input logic done, input logic und);
        beat_t b;
        b.en = en; b.er = er; b.d = d; b.done = done; b.und = und;
        return b;
    endfunction

    function automatic beat_t obs();
        return mk(o_en, o_er, o_txd, o_done, o_und);
    endfunction

    // Expected GMII stream, one entry per enabled edge, built from the frame list.
    task automatic build_expected(input bit pad);
        int idx;
        logic [31:0] crc, fcs;
        idx = 0;
        exp_q.delete();
        foreach (flen_q[f]) begin
            for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0));
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < flen_q[f]; i++) begin
                exp_q.push_back(mk(1'b1, 1'b0, byte_q[idx], 1'b0, 1'b0));
                crc = crc_upd(crc, byte_q[idx]);
                idx++;
            end
            if (fab_q[f]) begin
                exp_q.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
            end else begin
                for (int n = flen_q[f]; pad && n < 60; n++) begin
                    exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
                    crc = crc_upd(crc, 8'h00);
                end
                fcs = ~crc;
                for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b0, fcs[8*k +: 8], k == 3, 1'b0));
            end
            for (int i = 0; i < 12; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
        end
    endtask

    task automatic reset_dut();
        reset_r_lo = 1'b1; en_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset_r_lo = 1'b0;
        byte_q.delete(); last_q.delete(); flen_q.delete(); fab_q.delete(); cap.delete();
        ptr = 0; hold_err = 0; ready_err = 0; pulse_err = 0;
    endtask

    task automatic add_frame(input int len, input int kind, input bit abort);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            case (kind)
                0:       b = 8'h31 + 8'(i);
                2:       b = 8'hAB;
                default: b = 8'($urandom);
            endcase
            byte_q.push_back(b);
            last_q.push_back(!abort && (i == len - 1));
        end
        flen_q.push_back(len);
        fab_q.push_back(abort);
    endtask

    // One clk250 cycle: drive inputs, sample 1 ns after the edge.
    task automatic step();
        bit    en_b, acc;
        beat_t prev, now;
        cyc++;
        case (en_mode)
            1:       en_i = 1'b1;
            2:       en_i = ((cyc % 2) == 0);
            default: en_i = 1'($urandom_range(0, 1));
        endcase
        if (ptr < byte_q.size()) begin
            s_valid_i = 1'b1; s_data_i = byte_q[ptr]; s_last_i = last_q[ptr];
        end else begin
            s_valid_i = 1'b0; s_data_i = 8'($urandom); s_last_i = 1'($urandom);
        end
        #1;
        if (!en_i && o_ready) ready_err++;
        acc  = s_valid_i && o_ready;
        en_b = en_i;
        prev = obs();
        @(posedge clk);
        #1;
        if (acc) ptr++;
        now = obs();
        if (en_b) cap.push_back(now);
        else begin
            if (now.en != prev.en || now.er != prev.er || now.d != prev.d) hold_err++;
            if (now.done || now.und) pulse_err++;
        end
    endtask

    task automatic run_and_compare(input bit pad, input int exp_txen, input logic [31:0] exp_fcs,
                                   input string tag);
        int budget, mm, txen_cnt, und_cnt, er_cnt, done_cnt, n_abort, d_last, d_first, nxt;
        logic [31:0] fcs;
        build_expected(pad);
        budget = 0;
        while (cap.size() < exp_q.size() && budget < 3000) begin
            step();
            budget++;
        end
        check(cap.size() == exp_q.size(), {tag, " stream_len"}, 32'(cap.size()), 32'(exp_q.size()));
        mm = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            if (cap[i] != exp_q[i]) begin mm = i; break; end
        end
        check(mm < 0, $sformatf("%s stream@%0d", tag, mm),
              (mm >= 0) ? 32'(cap[mm]) : 32'h0, (mm >= 0) ? 32'(exp_q[mm]) : 32'h0);
        txen_cnt = 0; und_cnt = 0; er_cnt = 0; done_cnt = 0; d_last = -1; d_first = -1; n_abort = 0;
        foreach (cap[i]) begin
            if (cap[i].en) txen_cnt++;
            if (cap[i].und) und_cnt++;
            if (cap[i].er) er_cnt++;
            if (cap[i].done) begin
                done_cnt++;
                d_last = i;
                if (d_first < 0) d_first = i;
            end
        end
        foreach (fab_q[f]) if (fab_q[f]) n_abort++;
        check(txen_cnt == exp_txen, {tag, " tx_en_cycles"}, 32'(txen_cnt), 32'(exp_txen));
        check(und_cnt == n_abort, {tag, " underrun_pulses"}, 32'(und_cnt), 32'(n_abort));
        check(er_cnt == n_abort, {tag, " tx_er_cycles"}, 32'(er_cnt), 32'(n_abort));
        check(done_cnt == flen_q.size() - n_abort, {tag, " frame_done_pulses"},
              32'(done_cnt), 32'(flen_q.size() - n_abort));
        if (exp_fcs != 32'h0) begin
            fcs = (d_last >= 3) ? {cap[d_last].d, cap[d_last-1].d, cap[d_last-2].d, cap[d_last-3].d} : 32'h0;
            check(fcs == exp_fcs, {tag, " fcs"}, fcs, exp_fcs);
        end
        if (flen_q.size() > 1 && d_first >= 0) begin
            nxt = -1;
            for (int i = d_first + 1; i < cap.size(); i++) if (cap[i].en) begin nxt = i; break; end
            check(nxt - d_first == 13, {tag, " ifg_gap"}, 32'(nxt - d_first), 32'd13);
        end
        check(hold_err == 0 && ready_err == 0 && pulse_err == 0, {tag, " strobe_timing"},
              32'(hold_err + ready_err + pulse_err), 32'h0);
        check(o_busy == 1'b0, {tag, " idle_after"}, 32'(o_busy), 32'h0);
    endtask

    initial begin
        vec_t vecs[8];
        int   nfr, len, exp_txen;
        bit   pad;

        vecs[0] = '{1'b0, 1, 1, 9,  0, 1'b0, 21,  32'hCBF43926};
        vecs[1] = '{1'b0, 2, 1, 9,  0, 1'b0, 21,  32'hCBF43926};
        vecs[2] = '{1'b1, 1, 1, 1,  2, 1'b0, 72,  32'h0};
        vecs[3] = '{1'b1, 1, 1, 3,  1, 1'b1, 12,  32'h0};
        vecs[4] = '{1'b1, 1, 2, 64, 1, 1'b0, 152, 32'h0};
        vecs[5] = '{1'b1, 0, 1, 59, 1, 1'b0, 72,  32'h0};
        vecs[6] = '{1'b1, 0, 1, 60, 1, 1'b0, 72,  32'h0};
        vecs[7] = '{1'b0, 0, 1, 5,  1, 1'b0, 17,  32'h0};

        init_tbl();
        cyc = 0; en_mode = 1; sel = 1'b0;
        reset_r_lo = 1'b1; en_i = 1'b0; s_valid_i = 1'b1; s_last_i = 1'b0; s_data_i = 8'h00;
        #1;
        check({n_en, n_er, n_txd, n_busy, n_done, n_und, n_ready} == 15'h0, "reset_nopad",
              32'({n_en, n_er, n_txd, n_busy, n_done, n_und, n_ready}), 32'h0);
        check({p_en, p_er, p_txd, p_busy, p_done, p_und, p_ready} == 15'h0, "reset_pad",
              32'({p_en, p_er, p_txd, p_busy, p_done, p_und, p_ready}), 32'h0);

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].pad;
            en_mode = vecs[v].en_mode;
            reset_dut();
            for (int f = 0; f < vecs[v].nfr; f++) add_frame(vecs[v].len, vecs[v].kind, vecs[v].abort);
            run_and_compare(vecs[v].pad, vecs[v].exp_txen, vecs[v].exp_fcs, $sformatf("vec%0d", v));
        end

        // Asynchronous reset in the middle of the payload, then a clean frame.
        sel = 1'b0; en_mode = 1;
        reset_dut();
        add_frame(20, 1, 1'b0);
        repeat (12) step();
        check(o_en == 1'b1 && o_busy == 1'b1, "mid_data_active", 32'({o_en, o_busy}), 32'h3);
        reset_r_lo = 1'b1;
        #1;
        check(o_en == 1'b0 && o_busy == 1'b0 && o_er == 1'b0, "async_reset",
              32'({o_en, o_busy, o_er}), 32'h0);
        reset_dut();
        add_frame(9, 0, 1'b0);
        run_and_compare(1'b0, 21, 32'hCBF43926, "after_reset");

        for (int r = 0; r < 16; r++) begin
            pad = 1'($urandom_range(0, 1));
            sel = pad;
            en_mode = $urandom_range(0, 2);
            reset_dut();
            nfr = $urandom_range(1, 2);
            exp_txen = 0;
            for (int f = 0; f < nfr; f++) begin
                len = $urandom_range(1, 90);
                add_frame(len, 1, 1'b0);
                exp_txen += 8 + ((pad && len < 60) ? 60 : len) + 4;
            end
            run_and_compare(pad, exp_txen, 32'h0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
